spi_master_gen: RTL and testbench

SPI_MASTER_GEN -- requirements
Module: spi_master_gen

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_clk_gen.sv | 36 +++
 rtl/spi_master_gen.sv | 135 +++++++++++++
 tb/tb_spi_master_gen.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types for the SPI master: FSM states, captured SPI mode and the
// helper that sizes the chip-select index.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_HOLD,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } mode_t;

    function automatic int cs_idx_w(input int num_cs);
        return (num_cs > 1) ? $clog2(num_cs) : 1;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period tick generator with SCLK leading/trailing edge strobes.
// Latency: tick every div+1 cycles while run is high; counter clears when idle.
// Backpressure: none, free-running while run is asserted.
module spi_clk_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             xfer,
    input  logic [DIV_W-1:0] div,
    output logic             tick,
    output logic             lead,
    output logic             trail
);

    logic [DIV_W-1:0] cnt;
    logic             phase;

    assign tick  = run && (cnt == div);
    assign lead  = tick && xfer && !phase;
    assign trail = tick && xfer && phase;

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick && xfer) begin
                phase <= ~phase;
            end
        end
    end

endmodule

// File: rtl/spi_master_gen.sv
// SPI master, one word per request, MSB first, modes 0-3; SPI_MASTER_GEN_LOOPBACK_EN adds loopback_i.
// Latency: done_o pulses (2*DATA_W+2)*(clk_div_i+1) cycles after accept.
// Backpressure: ready_o high only in IDLE; start_i ignored otherwise.
module spi_master_gen
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 4,
    parameter int DIV_W  = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    output logic                        ready_o,
    input  logic [DATA_W-1:0]           data_i,
    input  logic [cs_idx_w(NUM_CS)-1:0] cs_sel_i,
    input  logic [1:0]                  mode_i,
    input  logic [DIV_W-1:0]            clk_div_i,
`ifdef SPI_MASTER_GEN_LOOPBACK_EN
    input  logic                        loopback_i,
`endif
    output logic [DATA_W-1:0]           data_o,
    output logic                        done_o,
    output logic                        sclk_o,
    output logic                        mosi_o,
    input  logic                        miso_i,
    output logic [NUM_CS-1:0]           cs_n_o
);

    localparam int CS_W   = cs_idx_w(NUM_CS);
    localparam int EDGE_W = $clog2(2 * DATA_W);

    state_t              state_q, state_d;
    mode_t               mode_q;
    logic [DIV_W-1:0]    div_q;
    logic [CS_W-1:0]     cs_q;
    logic [DATA_W:0]     tx_q;
    logic [DATA_W-1:0]   rx_q;
    logic [DATA_W-1:0]   data_q;
    logic [EDGE_W-1:0]   ecnt_q;
    logic                sclk_q;
    logic                accept, active, tick, lead, trail;
    logic                shift_en, sample_en, sample_bit;

    assign ready_o = (state_q == ST_IDLE) && !rst_i;
    assign accept  = start_i && ready_o;
    assign active  = (state_q == ST_SETUP) || (state_q == ST_XFER) || (state_q == ST_HOLD);
    assign done_o  = (state_q == ST_DONE);
    assign data_o  = data_q;
    assign sclk_o  = sclk_q;
    // tx_q carries one spare bit so both phases drive mosi from the top bit
    assign mosi_o  = active ? tx_q[DATA_W] : 1'b0;

    assign shift_en  = mode_q.cpha ? lead : trail;
    assign sample_en = mode_q.cpha ? trail : lead;

`ifdef SPI_MASTER_GEN_LOOPBACK_EN
    logic loop_q;
    assign sample_bit = loop_q ? mosi_o : miso_i;
`else
    assign sample_bit = miso_i;
`endif

    spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
        .clk   (clk_i),
        .rst   (rst_i),
        .run   (active),
        .xfer  (state_q == ST_XFER),
        .div   (div_q),
        .tick  (tick),
        .lead  (lead),
        .trail (trail)
    );

    always_comb begin
        state_d = state_q;
        cs_n_o  = '1;
        unique case (state_q)
            ST_IDLE:  if (accept) state_d = ST_SETUP;
            ST_SETUP: if (tick) state_d = ST_XFER;
            ST_XFER:  if (tick && ecnt_q == EDGE_W'(2 * DATA_W - 1)) state_d = ST_HOLD;
            ST_HOLD:  if (tick) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        // out-of-range index matches no line, so every select stays high
        for (int i = 0; i < NUM_CS; i++) begin
            if (active && cs_q == CS_W'(i)) cs_n_o[i] = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            mode_q  <= '0;
            div_q   <= '0;
            cs_q    <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            data_q  <= '0;
            ecnt_q  <= '0;
            sclk_q  <= 1'b0;
`ifdef SPI_MASTER_GEN_LOOPBACK_EN
            loop_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                mode_q <= mode_t'(mode_i);
                div_q  <= clk_div_i;
                cs_q   <= cs_sel_i;
                tx_q   <= mode_i[0] ? {1'b0, data_i} : {data_i, 1'b0};
                rx_q   <= '0;
                ecnt_q <= '0;
`ifdef SPI_MASTER_GEN_LOOPBACK_EN
                loop_q <= loopback_i;
`endif
            end
            if (accept) begin
                sclk_q <= mode_i[1];
            end else if (state_q == ST_XFER) begin
                if (tick) begin
                    sclk_q <= ~sclk_q;
                    ecnt_q <= ecnt_q + 1'b1;
                end
            end else begin
                sclk_q <= mode_q.cpol;
            end
            if (shift_en)  tx_q <= {tx_q[DATA_W-1:0], 1'b0};
            if (sample_en) rx_q <= {rx_q[DATA_W-2:0], sample_bit};
            if (state_q == ST_HOLD && tick) data_q <= rx_q;
        end
    end

endmodule

// File: tb/tb_spi_master_gen.sv
// Directed bench for spi_master_gen: vector table plus reset, back-to-back and loopback sequences.
module tb_spi_master_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] data = '0;
    logic [1:0] cs_sel = '0;
    logic [1:0] mode = '0;
    logic [7:0] div = '0;
    logic       miso;
`ifdef SPI_MASTER_GEN_LOOPBACK_EN
    logic       loopback = 1'b0;
`endif

    logic       ready_o, done_o, sclk_o, mosi_o;
    logic [7:0] data_o;
    logic [3:0] cs_n;
    logic       ready3, done3, sclk3, mosi3;
    logic [7:0] data3;
    logic [2:0] cs_n3;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_master_gen u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .ready_o(ready_o),
        .data_i(data), .cs_sel_i(cs_sel), .mode_i(mode), .clk_div_i(div),
`ifdef SPI_MASTER_GEN_LOOPBACK_EN
        .loopback_i(loopback),
`endif
        .data_o(data_o), .done_o(done_o), .sclk_o(sclk_o), .mosi_o(mosi_o),
        .miso_i(miso), .cs_n_o(cs_n)
    );

    // Three-select instance: index 3 is out of range here
    spi_master_gen #(.NUM_CS(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .ready_o(ready3),
        .data_i(data), .cs_sel_i(cs_sel), .mode_i(mode), .clk_div_i(div),
`ifdef SPI_MASTER_GEN_LOOPBACK_EN
        .loopback_i(loopback),
`endif
        .data_o(data3), .done_o(done3), .sclk_o(sclk3), .mosi_o(mosi3),
        .miso_i(miso), .cs_n_o(cs_n3)
    );

    // Slave: shifts on trailing edges (CPHA=0) or presents on leading edges (CPHA=1)
    int         slv_neg = 0;
    int         slv_base = 0;
    logic [7:0] slv_word = '0;
    logic       slv_cpha = 1'b0;
    logic [7:0] mosi_cap = '0;

    always @(negedge sclk_o) slv_neg <= slv_neg + 1;
    always @(posedge sclk_o) mosi_cap <= {mosi_cap[6:0], mosi_o};

    always_comb begin
        int idx;
        idx  = slv_neg - slv_base - (slv_cpha ? 1 : 0);
        miso = slv_word[7];
        if (idx >= 8)     miso = 1'b0;
        else if (idx > 0) miso = slv_word[3'(7 - idx)];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_xfer(
        input  logic [1:0] m, input logic [7:0] dv, input logic [7:0] d, input logic [7:0] sw,
        input  logic [1:0] cs, input logic lb, input logic [3:0] exp_cs, input logic [2:0] exp_cs3,
        output logic [7:0] rx, output int lat, output int lat3, output logic cs_ok, output logic cs3_ok,
        output int toggles, output logic tog_ok, output logic sclk_setup, output logic pulse_ok);
        int   acc, last_t;
        logic prev, got, got3;
        rx = '0; lat = -1; lat3 = -1; cs_ok = 1'b1; cs3_ok = 1'b1;
        toggles = 0; tog_ok = 1'b1; sclk_setup = 1'bx; pulse_ok = 1'b0; got = 1'b0; got3 = 1'b0;
        slv_word = sw;
        slv_cpha = m[0];
        for (int i = 0; i < 100 && !ready_o; i++) @(negedge clk);
        if (!ready_o) begin
            check("ready_wait", 32'(ready_o), 32'd1);
            return;
        end
        mode = m; div = dv; data = d; cs_sel = cs; start = 1'b1;
`ifdef SPI_MASTER_GEN_LOOPBACK_EN
        loopback = lb;
`endif
        @(negedge clk);
        acc = cyc;
        start = 1'b0;
        data = ~d; mode = ~m; div = dv + 8'd5; cs_sel = cs + 2'd1;
`ifdef SPI_MASTER_GEN_LOOPBACK_EN
        loopback = ~lb;
`endif
        slv_base = slv_neg;
        sclk_setup = sclk_o;
        prev = sclk_o;
        last_t = acc + int'(dv) + 1;
        for (int k = 0; k < 4000 && !(got && got3); k++) begin
            if (!got && cs_n !== exp_cs) cs_ok = 1'b0;
            if (!got3 && cs_n3 !== exp_cs3) cs3_ok = 1'b0;
            @(negedge clk);
            start = (cyc == acc + 3);
            if (sclk_o !== prev) begin
                toggles++;
                if (cyc - last_t != int'(dv) + 1) tog_ok = 1'b0;
                last_t = cyc;
                prev = sclk_o;
            end
            if (done3 && !got3) begin
                got3 = 1'b1; lat3 = cyc - acc;
                if (cs_n3 !== 3'b111) cs3_ok = 1'b0;
            end
            if (done_o && !got) begin
                got = 1'b1; lat = cyc - acc; rx = data_o;
                if (cs_n !== 4'hF) cs_ok = 1'b0;
            end
        end
        start = 1'b0;
        @(negedge clk);
        pulse_ok = got && !done_o && data_o == rx && mosi_o == 1'b0 && ready_o;
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [7:0] div;
        logic [7:0] data;
        logic [7:0] slv;
        logic [7:0] exp_rx;
        logic [1:0] cs;
        int         exp_lat;
        logic [3:0] exp_cs;
        logic [2:0] exp_cs3;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [7:0] rx;
        int         lat, lat3, toggles, nacc, ndone, ndone_rst;
        int         acc_c[4];
        int         done_c[4];
        logic       cs_ok, cs3_ok, tog_ok, sclk_setup, pulse_ok, b2b_ok;
        logic [3:0] exp_b;

        vecs[0] = '{2'd0, 8'd0, 8'hA5, 8'h3C, 8'h3C, 2'd0, 18, 4'b1110, 3'b110};
        vecs[1] = '{2'd3, 8'd3, 8'hFF, 8'h96, 8'h96, 2'd1, 72, 4'b1101, 3'b101};
        vecs[2] = '{2'd0, 8'd2, 8'h5A, 8'hC3, 8'hC3, 2'd3, 54, 4'b0111, 3'b111};
        vecs[3] = '{2'd3, 8'd0, 8'h81, 8'h7E, 8'h7E, 2'd2, 18, 4'b1011, 3'b011};
        vecs[4] = '{2'd0, 8'd1, 8'h0F, 8'hF0, 8'hF0, 2'd0, 36, 4'b1110, 3'b110};

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready_o), 32'd0);
        check("rst_done",  32'(done_o),  32'd0);
        check("rst_data",  32'(data_o),  32'd0);
        check("rst_sclk",  32'(sclk_o),  32'd0);
        check("rst_mosi",  32'(mosi_o),  32'd0);
        check("rst_cs_n",  32'(cs_n),    32'hF);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(ready_o), 32'd1);

        for (int v = 0; v < 5; v++) begin
            run_xfer(vecs[v].mode, vecs[v].div, vecs[v].data, vecs[v].slv, vecs[v].cs, 1'b0,
                     vecs[v].exp_cs, vecs[v].exp_cs3, rx, lat, lat3, cs_ok, cs3_ok,
                     toggles, tog_ok, sclk_setup, pulse_ok);
            check($sformatf("v%0d_data_o", v),  32'(rx),         32'(vecs[v].exp_rx));
            check($sformatf("v%0d_latency", v), 32'(lat),        32'(vecs[v].exp_lat));
            check($sformatf("v%0d_mosi", v),    32'(mosi_cap),   32'(vecs[v].data));
            check($sformatf("v%0d_cs_n", v),    32'(cs_ok),      32'd1);
            check($sformatf("v%0d_cs_n3", v),   32'(cs3_ok),     32'd1);
            check($sformatf("v%0d_latency3", v), 32'(lat3),      32'(vecs[v].exp_lat));
            check($sformatf("v%0d_toggles", v), 32'(toggles),    32'd16);
            check($sformatf("v%0d_half_per", v), 32'(tog_ok),    32'd1);
            check($sformatf("v%0d_sclk_idle", v), 32'(sclk_setup), 32'(vecs[v].mode[1]));
            check($sformatf("v%0d_done_pulse", v), 32'(pulse_ok), 32'd1);
        end

        // start held high: two words back to back on select 2
        mode = 2'd0; div = 8'd0; data = 8'h33; cs_sel = 2'd2;
        slv_word = 8'hE7; slv_cpha = 1'b0; slv_base = slv_neg;
        start = 1'b1; nacc = 0; ndone = 0; b2b_ok = 1'b1;
        for (int k = 0; k < 200 && ndone < 2; k++) begin
            @(negedge clk);
            if (ready_o && start && nacc < 4) begin
                acc_c[nacc] = cyc + 1; nacc++;
                slv_base = slv_neg;
            end
            if (done_o && ndone < 4) begin
                done_c[ndone] = cyc; ndone++;
                if (ndone == 2) start = 1'b0;
            end
            exp_b = (ready_o || done_o) ? 4'hF : 4'b1011;
            if (cs_n !== exp_b) b2b_ok = 1'b0;
        end
        start = 1'b0;
        check("b2b_dones", 32'(ndone), 32'd2);
        check("b2b_gap", 32'(acc_c[0] - done_c[0]), 32'd2);
        check("b2b_cs_n", 32'(b2b_ok), 32'd1);
        check("b2b_data", 32'(data_o), 32'hE7);

        // reset in the middle of the data phase
        repeat (2) @(negedge clk);
        mode = 2'd0; div = 8'd0; data = 8'hC6; cs_sel = 2'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_cs_n",  32'(cs_n),    32'hF);
        check("abort_sclk",  32'(sclk_o),  32'd0);
        check("abort_done",  32'(done_o),  32'd0);
        check("abort_ready", 32'(ready_o), 32'd0);
        check("abort_data",  32'(data_o),  32'd0);
        rst = 1'b0;
        ndone_rst = 0;
        @(negedge clk);
        check("abort_ready_after", 32'(ready_o), 32'd1);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done_o) ndone_rst++;
        end
        check("abort_no_done", 32'(ndone_rst), 32'd0);

`ifdef SPI_MASTER_GEN_LOOPBACK_EN
        for (int m = 0; m < 4; m++) begin
            run_xfer(2'(m), 8'd1, 8'h5A, 8'h00, 2'd0, 1'b1, 4'b1110, 3'b110,
                     rx, lat, lat3, cs_ok, cs3_ok, toggles, tog_ok, sclk_setup, pulse_ok);
            check($sformatf("loop_m%0d_data", m), 32'(rx),  32'h5A);
            check($sformatf("loop_m%0d_lat", m),  32'(lat), 32'd36);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no end of test, expected end of test");
        $fatal(1, "watchdog");
    end

endmodule
